// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, request kind,
// RV32I Funct3 encodings and the access-size byte mask.
package lsu_pkg;

    typedef enum logic [1:0] {IDLE, FIRST, SECOND, DONE} lsu_state_t;

    typedef enum logic {KIND_LOAD, KIND_STORE} lsu_kind_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Size encoding 2'b11 is not a legal RV32I width and falls through to word.
    function automatic logic [3:0] byte_mask(input logic [1:0] size);
        if (size == F3_B[1:0])      return 4'b0001;
        else if (size == F3_H[1:0]) return 4'b0011;
        else                        return 4'b1111;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store data/byte enables across a two-word window,
// and realignment plus sign/zero extension of loaded data.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata1,
    input  logic [31:0] rdata0,
    output logic [7:0]  lane_mask,
    output logic [63:0] wdata_shifted,
    output logic [31:0] rdata_ext
);

    logic [31:0] rd_shifted;

    assign lane_mask     = {4'b0000, byte_mask(funct3[1:0])} << offset;
    assign wdata_shifted = {32'b0, wdata} << {offset, 3'b000};

    // NOTE: every variable written in always_comb gets a value on every path,
    // otherwise synthesis infers a latch.
    always_comb begin
        rd_shifted = 32'({rdata1, rdata0} >> {offset, 3'b000});
        case (funct3)
            F3_B:    rdata_ext = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
            F3_BU:   rdata_ext = {24'b0, rd_shifted[7:0]};
            F3_H:    rdata_ext = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
            F3_HU:   rdata_ext = {16'b0, rd_shifted[15:0]};
            F3_W:    rdata_ext = rd_shifted;
            default: rdata_ext = rd_shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: byte-addressed accesses become one or two word accesses
// to a synchronous-read data memory, behind a ready/valid request handshake.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 9,
    parameter int DATA_WIDTH    = 32
)
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ReqValid,
    output logic                     ReqReady,
    input  logic [ADDRESS_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0]    WriteData,
    input  logic                     MemRead,
    input  logic                     MemWrite,
    input  logic [2:0]               Funct3,
    output logic                     RespValid,
    output logic [DATA_WIDTH-1:0]    ReadData,
    output logic [ADDRESS_WIDTH-3:0] MemAddr,
    output logic [DATA_WIDTH-1:0]    MemWdata,
    output logic [3:0]               MemBe,
    output logic                     MemRe,
    input  logic [DATA_WIDTH-1:0]    MemRdata
);

    localparam int WAW = ADDRESS_WIDTH - 2;

    lsu_state_t          state_q, state_d;
    lsu_kind_t           kind_q, kind_d;
    logic [2:0]          funct3_q, funct3_d;
    logic [1:0]          offset_q, offset_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                split_q, split_d;
    logic [31:0]         rdata0_q, rdata0_d;
    logic                ready_q, ready_d;
    logic                resp_valid_q, resp_valid_d;
    logic [31:0]         read_data_q, read_data_d;
    logic [WAW-1:0]      mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic [3:0]          mem_be_q, mem_be_d;
    logic                mem_re_q, mem_re_d;

    logic                idle;
    logic [2:0]          al_funct3;
    logic [1:0]          al_offset;
    logic [31:0]         al_wdata;
    logic [31:0]         al_rdata1;
    logic [31:0]         al_rdata0;
    logic [7:0]          lane;
    logic [63:0]         shifted;
    logic [31:0]         load_result;

    // On accept the aligner sees the live request; afterwards the latched copy.
    assign idle      = (state_q == IDLE);
    assign al_funct3 = idle ? Funct3 : funct3_q;
    assign al_offset = idle ? Address[1:0] : offset_q;
    assign al_wdata  = idle ? WriteData : wdata_q;
    assign al_rdata1 = split_q ? MemRdata : 32'b0;
    assign al_rdata0 = split_q ? rdata0_q : MemRdata;

    lsu_align u_align (
        .funct3        (al_funct3),
        .offset        (al_offset),
        .wdata         (al_wdata),
        .rdata1        (al_rdata1),
        .rdata0        (al_rdata0),
        .lane_mask     (lane),
        .wdata_shifted (shifted),
        .rdata_ext     (load_result)
    );

    always_comb begin
        state_d      = state_q;
        kind_d       = kind_q;
        funct3_d     = funct3_q;
        offset_d     = offset_q;
        wdata_d      = wdata_q;
        split_d      = split_q;
        rdata0_d     = rdata0_q;
        read_data_d  = read_data_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        resp_valid_d = 1'b0;
        mem_be_d     = 4'b0000;
        mem_re_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (ReqValid && (MemRead || MemWrite)) begin
                    kind_d      = MemRead ? KIND_LOAD : KIND_STORE;
                    funct3_d    = Funct3;
                    offset_d    = Address[1:0];
                    wdata_d     = WriteData;
                    split_d     = |lane[7:4];
                    mem_addr_d  = Address[ADDRESS_WIDTH-1:2];
                    mem_wdata_d = shifted[31:0];
                    if (MemRead) mem_re_d = 1'b1;
                    else         mem_be_d = lane[3:0];
                    state_d     = FIRST;
                end
            end
            FIRST: begin
                if (split_q) begin
                    mem_addr_d  = mem_addr_q + WAW'(1);
                    mem_wdata_d = shifted[63:32];
                    if (kind_q == KIND_LOAD) mem_re_d = 1'b1;
                    else                     mem_be_d = lane[7:4];
                    state_d     = SECOND;
                end else begin
                    state_d = (kind_q == KIND_LOAD) ? DONE : IDLE;
                end
            end
            SECOND: begin
                if (kind_q == KIND_LOAD) begin
                    rdata0_d = MemRdata;
                    state_d  = DONE;
                end else begin
                    state_d  = IDLE;
                end
            end
            DONE: begin
                read_data_d  = load_result;
                resp_valid_d = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            kind_q       <= KIND_LOAD;
            funct3_q     <= 3'b000;
            offset_q     <= 2'b00;
            wdata_q      <= 32'b0;
            split_q      <= 1'b0;
            rdata0_q     <= 32'b0;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            read_data_q  <= 32'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'b0;
            mem_be_q     <= 4'b0000;
            mem_re_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            kind_q       <= kind_d;
            funct3_q     <= funct3_d;
            offset_q     <= offset_d;
            wdata_q      <= wdata_d;
            split_q      <= split_d;
            rdata0_q     <= rdata0_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            read_data_q  <= read_data_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_be_q     <= mem_be_d;
            mem_re_q     <= mem_re_d;
        end
    end

    assign ReqReady  = ready_q;
    assign RespValid = resp_valid_q;
    assign ReadData  = read_data_q;
    assign MemAddr   = mem_addr_q;
    assign MemWdata  = mem_wdata_q;
    assign MemBe     = mem_be_q;
    assign MemRe     = mem_re_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 128-word synchronous-read memory model.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ReqValid;
    logic        ReqReady;
    logic [8:0]  Address;
    logic [31:0] WriteData;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  Funct3;
    logic        RespValid;
    logic [31:0] ReadData;
    logic [6:0]  MemAddr;
    logic [31:0] MemWdata;
    logic [3:0]  MemBe;
    logic        MemRe;
    logic [31:0] MemRdata;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mem [128];
    logic        mem_init;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ReqValid  (ReqValid),
        .ReqReady  (ReqReady),
        .Address   (Address),
        .WriteData (WriteData),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Funct3    (Funct3),
        .RespValid (RespValid),
        .ReadData  (ReadData),
        .MemAddr   (MemAddr),
        .MemWdata  (MemWdata),
        .MemBe     (MemBe),
        .MemRe     (MemRe),
        .MemRdata  (MemRdata)
    );

    function automatic logic [31:0] init_word(input int i);
        case (i)
            0:       return 32'h7788_1122;
            4:       return 32'hDEAD_BEEF;
            8:       return 32'hCAFE_F00D;
            64:      return 32'h5555_5555;
            127:     return 32'h3344_5566;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 128; i++) mem[i] <= init_word(i);
            MemRdata <= 32'h0;
        end else begin
            if (MemRe) MemRdata <= mem[MemAddr];
            for (int b = 0; b < 4; b++)
                if (MemBe[b]) mem[MemAddr][8*b +: 8] <= MemWdata[8*b +: 8];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive_req(input logic [8:0] addr, input logic [2:0] f3,
                             input logic [31:0] wd, input logic rd, input logic wr);
        ReqValid  = 1'b1;
        Address   = addr;
        Funct3    = f3;
        WriteData = wd;
        MemRead   = rd;
        MemWrite  = wr;
    endtask

    // Called at a negedge; returns at the negedge of the RespValid cycle.
    task automatic do_load(input string tag, input logic [8:0] addr, input logic [2:0] f3,
                           input logic wr, input logic split, input logic [6:0] a0,
                           input logic [31:0] exp);
        logic [6:0] a1;
        a1 = a0 + 7'd1;
        check({tag, "/ready_in"}, 32'(ReqReady), 32'd1);
        drive_req(addr, f3, 32'h1234_5678, 1'b1, wr);
        @(posedge clk);
        @(negedge clk);
        ReqValid = 1'b0;
        check({tag, "/re0"}, 32'(MemRe), 32'd1);
        check({tag, "/addr0"}, 32'(MemAddr), 32'(a0));
        check({tag, "/be0"}, 32'(MemBe), 32'd0);
        check({tag, "/busy0"}, 32'(ReqReady), 32'd0);
        if (split) begin
            @(negedge clk);
            check({tag, "/re1"}, 32'(MemRe), 32'd1);
            check({tag, "/addr1"}, 32'(MemAddr), 32'(a1));
            check({tag, "/be1"}, 32'(MemBe), 32'd0);
        end
        @(negedge clk);
        check({tag, "/done_re"}, 32'(MemRe), 32'd0);
        check({tag, "/done_rv"}, 32'(RespValid), 32'd0);
        check({tag, "/done_busy"}, 32'(ReqReady), 32'd0);
        @(negedge clk);
        check({tag, "/rv"}, 32'(RespValid), 32'd1);
        check({tag, "/data"}, ReadData, exp);
        check({tag, "/ready_out"}, 32'(ReqReady), 32'd1);
    endtask

    // Called at a negedge; returns at the negedge of the first ready cycle.
    task automatic do_store(input string tag, input logic [8:0] addr, input logic [2:0] f3,
                            input logic [31:0] wd, input logic split, input logic [6:0] a0,
                            input logic [3:0] be0, input logic [31:0] wd0,
                            input logic [3:0] be1, input logic [31:0] wd1);
        logic [6:0] a1;
        a1 = a0 + 7'd1;
        check({tag, "/ready_in"}, 32'(ReqReady), 32'd1);
        drive_req(addr, f3, wd, 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        ReqValid = 1'b0;
        check({tag, "/be0"}, 32'(MemBe), 32'(be0));
        check({tag, "/addr0"}, 32'(MemAddr), 32'(a0));
        check({tag, "/wd0"}, MemWdata, wd0);
        check({tag, "/re0"}, 32'(MemRe), 32'd0);
        check({tag, "/busy0"}, 32'(ReqReady), 32'd0);
        if (split) begin
            @(negedge clk);
            check({tag, "/be1"}, 32'(MemBe), 32'(be1));
            check({tag, "/addr1"}, 32'(MemAddr), 32'(a1));
            check({tag, "/wd1"}, MemWdata, wd1);
            check({tag, "/busy1"}, 32'(ReqReady), 32'd0);
        end
        @(negedge clk);
        check({tag, "/ready_out"}, 32'(ReqReady), 32'd1);
        check({tag, "/be_idle"}, 32'(MemBe), 32'd0);
        check({tag, "/no_rv"}, 32'(RespValid), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        mem_init  = 1'b1;
        ReqValid  = 1'b0;
        Address   = 9'h0;
        WriteData = 32'h0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        Funct3    = 3'b000;
        repeat (3) @(negedge clk);
        rst_n    = 1'b1;
        mem_init = 1'b0;

        check("rst/ready", 32'(ReqReady), 32'd1);
        check("rst/rv", 32'(RespValid), 32'd0);
        check("rst/rdata", ReadData, 32'h0);
        check("rst/addr", 32'(MemAddr), 32'd0);
        check("rst/wdata", MemWdata, 32'h0);
        check("rst/be", 32'(MemBe), 32'd0);
        check("rst/re", 32'(MemRe), 32'd0);

        do_load("lw_010", 9'h010, F3_W, 1'b0, 1'b0, 7'd4, 32'hDEAD_BEEF);
        // Accepted in the same cycle as the LW response.
        do_store("sw_010", 9'h010, F3_W, 32'h80FF_7F01, 1'b0, 7'd4,
                 4'b1111, 32'h80FF_7F01, 4'b0000, 32'h0);
        check("hold_after_sw", ReadData, 32'hDEAD_BEEF);

        do_load("lb_013", 9'h013, F3_B, 1'b0, 1'b0, 7'd4, 32'hFFFF_FF80);
        do_load("lbu_013", 9'h013, F3_BU, 1'b0, 1'b0, 7'd4, 32'h0000_0080);
        do_load("lh_012", 9'h012, F3_H, 1'b0, 1'b0, 7'd4, 32'hFFFF_80FF);
        do_load("lhu_012", 9'h012, F3_HU, 1'b0, 1'b0, 7'd4, 32'h0000_80FF);
        do_load("lh_011", 9'h011, F3_H, 1'b0, 1'b0, 7'd4, 32'hFFFF_FF7F);

        do_store("sh_007", 9'h007, F3_H, 32'h0000_ABCD, 1'b1, 7'd1,
                 4'b1000, 32'hCD00_0000, 4'b0001, 32'h0000_00AB);
        check("sh_007/mem1", mem[1], 32'hCD00_0000);
        check("sh_007/mem2", mem[2], 32'h0000_00AB);

        do_store("sb_032", 9'h032, F3_B, 32'h0000_00EE, 1'b0, 7'd12,
                 4'b0100, 32'h00EE_0000, 4'b0000, 32'h0);
        do_load("lw_030", 9'h030, F3_W, 1'b0, 1'b0, 7'd12, 32'h00EE_0000);

        do_load("lw_1fe_wrap", 9'h1FE, F3_W, 1'b0, 1'b1, 7'd127, 32'h1122_3344);

        do_load("rdwr_020", 9'h020, F3_W, 1'b1, 1'b0, 7'd8, 32'hCAFE_F00D);
        check("rdwr_020/mem8", mem[8], 32'hCAFE_F00D);

        drive_req(9'h044, F3_W, 32'hFFFF_FFFF, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        ReqValid = 1'b0;
        check("noop/ready", 32'(ReqReady), 32'd1);
        check("noop/re", 32'(MemRe), 32'd0);
        check("noop/be", 32'(MemBe), 32'd0);
        @(negedge clk);
        check("noop/rv", 32'(RespValid), 32'd0);

        // Abort a split store while its second word is on the bus.
        drive_req(9'h0FD, F3_W, 32'hA1B2_C3D4, 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        ReqValid = 1'b0;
        check("abort/be0", 32'(MemBe), 32'b1110);
        check("abort/wd0", MemWdata, 32'hB2C3_D400);
        @(negedge clk);
        check("abort/be1", 32'(MemBe), 32'b0001);
        check("abort/addr1", 32'(MemAddr), 32'd64);
        rst_n = 1'b0;
        #1;
        check("abort/be_now", 32'(MemBe), 32'd0);
        check("abort/re_now", 32'(MemRe), 32'd0);
        check("abort/rv_now", 32'(RespValid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("abort/mem63", mem[63], 32'hB2C3_D400);
        check("abort/mem64", mem[64], 32'h5555_5555);
        check("abort/rdata", ReadData, 32'h0);
        @(negedge clk);
        check("abort/ready", 32'(ReqReady), 32'd1);
        check("abort/rv", 32'(RespValid), 32'd0);
        check("abort/be", 32'(MemBe), 32'd0);

        do_load("lw_after_abort", 9'h010, F3_W, 1'b0, 1'b0, 7'd4, 32'h80FF_7F01);
        @(negedge clk);
        check("rv_pulse", 32'(RespValid), 32'd0);
        check("rdata_hold", ReadData, 32'h80FF_7F01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
